// File: rtl/io_pkg.sv
// Shared encodings for the I/O port controller: FSM states, transfer direction, abort data.
package io_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

   // Wide enough for any DW up to 64; users slice [DW-1:0].
   localparam logic [63:0] ERR_DATA = '1;

endpackage

// File: rtl/io_timeout.sv
// REQ-phase cycle counter for the I/O controller; hit flags cnt==TIMEOUT.
module io_timeout #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign hit = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/io_port_ctrl.sv
// IN/OUT sequencer: req/ack handshake to NPORTS ports with CPU stall and done pulse.
// Define IO_TIMEOUT_EN to abort a REQ that sees no ack within TIMEOUT cycles.
module io_port_ctrl
   import io_pkg::*;
#(
   parameter int NPORTS  = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_rd,
   input  logic                 io_wr,
   input  logic [3:0]           port_sel,
   input  logic [DW-1:0]        wdata,
   output logic [DW-1:0]        rdata,
   output logic                 stall,
   output logic                 done,
   output logic                 err,
   output logic [NPORTS-1:0]    p_req,
   output logic                 p_we,
   output logic [DW-1:0]        p_wdata,
   input  logic [NPORTS*DW-1:0] p_rdata,
   input  logic [NPORTS-1:0]    p_ack
);

   state_t              state_q, state_d;
   logic [3:0]          sel_q, sel_d;
   logic                dir_q, dir_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [NPORTS-1:0]   p_req_q, p_req_d;
   logic                p_we_q, p_we_d;
   logic [DW-1:0]       p_wdata_q, p_wdata_d;

   logic                launch, bad_port, ack_sel, timeout_hit;
   logic [DW-1:0]       rdata_sel;

   assign launch   = io_rd | io_wr;
   assign bad_port = ({1'b0, port_sel} >= 5'(NPORTS));

   // Mux by loop so the 4-bit select never indexes past NPORTS.
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (sel_q == 4'(i)) begin
            ack_sel   = p_ack[i];
            rdata_sel = p_rdata[i*DW +: DW];
         end
      end
   end

`ifdef IO_TIMEOUT_EN
   // Counts the launch cycle plus each REQ cycle, so hit lands on REQ cycle TIMEOUT.
   io_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr   (~stall),
      .en    (stall),
      .hit   (timeout_hit)
   );
`else
   localparam int unused_timeout = TIMEOUT;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      dir_d     = dir_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      err_d     = err_q;
      p_req_d   = p_req_q;
      p_we_d    = p_we_q;
      p_wdata_d = p_wdata_q;
      stall     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (launch) begin
               stall     = 1'b1;
               sel_d     = port_sel;
               dir_d     = io_wr ? DIR_WR : DIR_RD;
               p_wdata_d = wdata;
               if (bad_port) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = ERR_DATA[DW-1:0];
               end else begin
                  state_d = S_REQ;
                  p_we_d  = io_wr;
                  for (int i = 0; i < NPORTS; i++)
                     p_req_d[i] = (port_sel == 4'(i));
               end
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (ack_sel) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b0;
               p_req_d = '0;
               p_we_d  = 1'b0;
               if (dir_q == DIR_RD)
                  rdata_d = rdata_sel;
            end else if (timeout_hit) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               p_req_d = '0;
               p_we_d  = 1'b0;
               rdata_d = ERR_DATA[DW-1:0];
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         dir_q     <= DIR_RD;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         p_req_q   <= '0;
         p_we_q    <= 1'b0;
         p_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         dir_q     <= dir_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         err_q     <= err_d;
         p_req_q   <= p_req_d;
         p_we_q    <= p_we_d;
         p_wdata_q <= p_wdata_d;
      end
   end

   assign rdata   = rdata_q;
   assign done    = done_q;
   assign err     = err_q;
   assign p_req   = p_req_q;
   assign p_we    = p_we_q;
   assign p_wdata = p_wdata_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl (NPORTS=4, DW=8); timeout scenario runs only with IO_TIMEOUT_EN.
module tb_io_port_ctrl;

   logic        clk = 1'b0;
   logic        reset, io_rd, io_wr;
   logic [3:0]  port_sel;
   logic [7:0]  wdata, rdata, p_wdata;
   logic        stall, done, err, p_we;
   logic [3:0]  p_req, p_ack;
   logic [31:0] p_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   io_port_ctrl #(.NPORTS(4), .DW(8), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .port_sel(port_sel),
      .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .err(err),
      .p_req(p_req), .p_we(p_we), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ack(p_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset = 1'b1; io_rd = 0; io_wr = 0; port_sel = 0; wdata = 0; p_ack = 0;
      p_rdata = {8'h44, 8'hA5, 8'h22, 8'h33};
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", rdata); end
      n_chk++; if ({stall, done, err, p_we} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {stall, done, err, p_we}); end
      n_chk++; if (p_req !== 4'b0000) begin n_fail++; $display("FAIL rst_p_req: got %b want 0000", p_req); end
      n_chk++; if (p_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_p_wdata: got %h want 00", p_wdata); end
      @(negedge clk); #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_no_stall: got %b want 0", stall); end
   endtask

   // IN port 2, ack seen at the end of REQ cycle 3.
   task automatic test_in_basic();
      @(negedge clk);
      io_rd = 1; port_sel = 4'd2;
      #1;
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL in_stall_idle: got %b want 1", stall); end
      n_chk++; if (p_req !== 4'b0000) begin n_fail++; $display("FAIL in_req_idle: got %b want 0000", p_req); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 3) p_ack = 4'b0100;
         #1;
         n_chk++; if ({stall, done} !== 2'b10) begin n_fail++; $display("FAIL in_req%0d_stall_done: got %b want 10", k, {stall, done}); end
         n_chk++; if (p_req !== 4'b0100 || p_we !== 1'b0) begin n_fail++; $display("FAIL in_req%0d_p_req: got %b/%b want 0100/0", k, p_req, p_we); end
      end
      @(negedge clk);
      p_ack = 0; io_rd = 0;
      #1;
      n_chk++; if ({stall, done, err} !== 3'b010) begin n_fail++; $display("FAIL in_done_flags: got %b want 010", {stall, done, err}); end
      n_chk++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL in_done_rdata: got %h want a5", rdata); end
      n_chk++; if (p_req !== 4'b0000) begin n_fail++; $display("FAIL in_done_p_req: got %b want 0000", p_req); end
      @(negedge clk); #1;
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL in_done_pulse: got %b want 0", done); end
   endtask

   // OUT port 1, wdata changes while REQ is held; ack after 2 REQ cycles.
   task automatic test_out_basic();
      @(negedge clk);
      io_wr = 1; port_sel = 4'd1; wdata = 8'h3C;
      #1;
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL out_stall_idle: got %b want 1", stall); end
      @(negedge clk);
      wdata = 8'h00; port_sel = 4'd3;
      #1;
      n_chk++; if (p_req !== 4'b0010 || p_we !== 1'b1 || p_wdata !== 8'h3C) begin n_fail++; $display("FAIL out_req1: got %b/%b/%h want 0010/1/3c", p_req, p_we, p_wdata); end
      @(negedge clk);
      p_ack = 4'b0010;
      #1;
      n_chk++; if (p_req !== 4'b0010 || p_wdata !== 8'h3C || stall !== 1'b1) begin n_fail++; $display("FAIL out_req2: got %b/%h/%b want 0010/3c/1", p_req, p_wdata, stall); end
      @(negedge clk);
      p_ack = 0; io_wr = 0;
      #1;
      n_chk++; if ({stall, done, err} !== 3'b010) begin n_fail++; $display("FAIL out_done_flags: got %b want 010", {stall, done, err}); end
      n_chk++; if (p_req !== 4'b0000) begin n_fail++; $display("FAIL out_done_p_req: got %b want 0000", p_req); end
      n_chk++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL out_rdata_kept: got %h want a5", rdata); end
   endtask

   // IN port 0 while port 3 acks for 5 cycles; only ack[0] completes it.
   task automatic test_foreign_ack();
      @(negedge clk);
      io_rd = 1; port_sel = 4'd0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         io_rd = 0;
         p_ack = (k == 6) ? 4'b0001 : 4'b1000;
         #1;
         n_chk++; if ({stall, done, p_req} !== 6'b10_0001) begin n_fail++; $display("FAIL fa_req%0d: got %b want 100001", k, {stall, done, p_req}); end
      end
      @(negedge clk);
      p_ack = 0;
      #1;
      n_chk++; if (done !== 1'b1 || rdata !== 8'h33) begin n_fail++; $display("FAIL fa_done: got %b/%h want 1/33", done, rdata); end
   endtask

   // Bad port: no request, done next cycle with err and all-ones; a good IN then clears err.
   task automatic test_bad_port(input logic [3:0] sel);
      @(negedge clk);
      io_rd = 1; port_sel = sel;
      #1;
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL bad%0d_stall: got %b want 1", sel, stall); end
      @(negedge clk);
      io_rd = 0;
      #1;
      n_chk++; if ({stall, done, err, p_req} !== 7'b011_0000) begin n_fail++; $display("FAIL bad%0d_done: got %b want 0110000", sel, {stall, done, err, p_req}); end
      n_chk++; if (rdata !== 8'hFF) begin n_fail++; $display("FAIL bad%0d_rdata: got %h want ff", sel, rdata); end
      @(negedge clk);
      io_rd = 1; port_sel = 4'd1;
      @(negedge clk);
      io_rd = 0; p_ack = 4'b0010;
      #1;
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad%0d_err_held: got %b want 1", sel, err); end
      @(negedge clk);
      p_ack = 0;
      #1;
      n_chk++; if ({done, err} !== 2'b10 || rdata !== 8'h22) begin n_fail++; $display("FAIL bad%0d_recover: got %b/%h want 10/22", sel, {done, err}, rdata); end
   endtask

   // Reset mid-REQ drops everything; then rd+wr together performs a write.
   task automatic test_reset_mid();
      @(negedge clk);
      io_rd = 1; port_sel = 4'd3;
      @(negedge clk);
      io_rd = 0;
      #1;
      n_chk++; if (p_req !== 4'b1000) begin n_fail++; $display("FAIL rm_req: got %b want 1000", p_req); end
      reset = 1;
      @(negedge clk);
      reset = 0;
      #1;
      n_chk++; if ({stall, done, p_req} !== 6'b00_0000 || rdata !== 8'h00) begin n_fail++; $display("FAIL rm_cleared: got %b/%h want 000000/00", {stall, done, p_req}, rdata); end
      io_rd = 1; io_wr = 1; port_sel = 4'd3; wdata = 8'h5A;
      @(negedge clk);
      io_rd = 0; io_wr = 0; p_ack = 4'b1000;
      #1;
      n_chk++; if (p_req !== 4'b1000 || p_we !== 1'b1 || p_wdata !== 8'h5A) begin n_fail++; $display("FAIL rm_wr_wins: got %b/%b/%h want 1000/1/5a", p_req, p_we, p_wdata); end
      @(negedge clk);
      p_ack = 0;
      #1;
      n_chk++; if (done !== 1'b1 || rdata !== 8'h00) begin n_fail++; $display("FAIL rm_wr_done: got %b/%h want 1/00", done, rdata); end
   endtask

`ifdef IO_TIMEOUT_EN
   task automatic test_timeout();
      int n_req = 0;
      bit seen = 0;
      @(negedge clk);
      io_rd = 1; port_sel = 4'd2;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         io_rd = 0;
         #1;
         if (done) seen = 1; else n_req++;
      end
      n_chk++; if (!seen || n_req != 15) begin n_fail++; $display("FAIL to_cycles: got %0d (done=%0d) want 15", n_req, seen); end
      n_chk++; if (err !== 1'b1 || rdata !== 8'hFF) begin n_fail++; $display("FAIL to_err: got %b/%h want 1/ff", err, rdata); end
      @(negedge clk);
      io_rd = 1; port_sel = 4'd1;
      @(negedge clk);
      io_rd = 0; p_ack = 4'b0010;
      @(negedge clk);
      p_ack = 0;
      #1;
      n_chk++; if ({done, err} !== 2'b10 || rdata !== 8'h22) begin n_fail++; $display("FAIL to_recover: got %b/%h want 10/22", {done, err}, rdata); end
   endtask
`endif

   initial begin
      test_reset();
      test_in_basic();
      test_out_basic();
      test_foreign_ack();
      test_bad_port(4'd4);
      test_bad_port(4'd15);
      test_reset_mid();
`ifdef IO_TIMEOUT_EN
      test_timeout();
`endif
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
